// File: rtl/prog_instruction_memory_if.sv
// Load and fetch port bundle for the program instruction memory.
// The master side (sequencer/loader) drives requests; the slave side is the memory.
interface prog_instruction_memory_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
);
  logic               ld_start;
  logic               ld_valid;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_ready;
  logic               ld_done;
  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               fetch_valid;
  logic [INSTR_W-1:0] instr;
  logic               busy;

  modport master (
    output ld_start, ld_valid, ld_data, fetch_req, fetch_addr,
    input  ld_ready, ld_done, fetch_valid, instr, busy
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, fetch_req, fetch_addr,
    output ld_ready, ld_done, fetch_valid, instr, busy
  );
endinterface

// File: rtl/prog_instruction_memory.sv
// Program store: sequential word-by-word loader (IDLE/LOAD/DONE) plus a
// single-cycle-latency fetch port that is only serviced while IDLE.
module prog_instruction_memory #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  prog_instruction_memory_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               wr_en;

  // Contents start cleared and are deliberately untouched by rst.
  logic [INSTR_W-1:0] mem [DEPTH] = '{default: '0};

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    fetch_valid_d = 1'b0;
    instr_d       = instr_q;
    wr_en         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.fetch_req) begin
          fetch_valid_d = 1'b1;
          instr_d       = mem[bus.fetch_addr];
        end
        if (bus.ld_start) begin
          ptr_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // A restart wins over a word offered in the same cycle.
        if (bus.ld_start) begin
          ptr_d = '0;
        end else if (bus.ld_valid) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      fetch_valid_q <= 1'b0;
      instr_q       <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      fetch_valid_q <= fetch_valid_d;
      instr_q       <= instr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[ptr_q] <= bus.ld_data;
    end
  end

  assign bus.ld_ready    = (state_q == LOAD);
  assign bus.ld_done     = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.instr       = instr_q;
endmodule

// File: tb/tb_prog_instruction_memory.sv
// Directed self-checking bench for prog_instruction_memory.
// Inputs are driven 1 time unit after each rising edge and outputs sampled there too.
module tb_prog_instruction_memory;
  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  prog_instruction_memory_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  prog_instruction_memory #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_start   = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = '0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
  endtask

  // Issue one fetch in IDLE and compare the returned word one cycle later.
  task automatic do_fetch(input logic [ADDR_W-1:0] addr, input logic [INSTR_W-1:0] exp);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    tick();
    bus.fetch_req  = 1'b0;
    n_cmp++;
    if (bus.fetch_valid !== 1'b1 || bus.instr !== exp) begin
      n_err++;
      $display("FAIL fetch addr=%0d: valid=%b instr=%02h, required valid=1 instr=%02h",
               addr, bus.fetch_valid, bus.instr, exp);
    end else begin
      $display("fetch addr=%0d instr=%02h", addr, bus.instr);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.fetch_valid !== 1'b0 || bus.instr !== 8'h00 || bus.ld_done !== 1'b0 ||
        bus.ld_ready !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: fv=%b instr=%02h done=%b ready=%b busy=%b, required all zero",
               bus.fetch_valid, bus.instr, bus.ld_done, bus.ld_ready, bus.busy);
    end else begin
      $display("reset state ok");
    end
  endtask

  task automatic test_fetch_zero();
    for (int a = 0; a < 4; a++) begin
      do_fetch(ADDR_W'(a), 8'h00);
    end
    tick();
    n_cmp++;
    if (bus.fetch_valid !== 1'b0 || bus.instr !== 8'h00) begin
      n_err++;
      $display("FAIL fetch_idle_hold: fv=%b instr=%02h, required fv=0 instr=00",
               bus.fetch_valid, bus.instr);
    end
  endtask

  task automatic test_load_full();
    int dones = 0;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_enter: busy=%b ready=%b, required 1 1", bus.busy, bus.ld_ready);
    end
    for (int i = 0; i < 16; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'h10 + 8'(i);
      tick();
      if (bus.ld_done === 1'b1) dones++;
      if (i == 15) begin
        n_cmp++;
        if (bus.ld_done !== 1'b1 || bus.ld_ready !== 1'b0 || bus.busy !== 1'b1) begin
          n_err++;
          $display("FAIL load_done_pulse: done=%b ready=%b busy=%b, required 1 0 1",
                   bus.ld_done, bus.ld_ready, bus.busy);
        end
      end
    end
    bus.ld_valid = 1'b0;
    tick();
    if (bus.ld_done === 1'b1) dones++;
    n_cmp++;
    if (dones != 1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL load_done_count: pulses=%0d busy=%b, required 1 pulse busy=0", dones, bus.busy);
    end else begin
      $display("load 0x10..0x1F complete");
    end
    do_fetch(4'd5, 8'h15);
    do_fetch(4'd0, 8'h10);
    do_fetch(4'd15, 8'h1F);
  endtask

  task automatic test_load_toggle();
    int c;
    int ready_bad = 0;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    c = 0;
    while (c < 40) begin
      bus.ld_valid = (c % 2 == 0);
      bus.ld_data  = (c % 2 == 0) ? 8'h10 + 8'(c / 2) : 8'hEE;
      tick();
      if (bus.ld_done === 1'b1) break;
      if (bus.ld_ready !== 1'b1) ready_bad++;
      c++;
    end
    n_cmp++;
    if (c != 30 || ready_bad != 0) begin
      n_err++;
      $display("FAIL toggle_timing: done after cycle %0d ready_drops=%0d, required cycle 30 drops 0",
               c, ready_bad);
    end else begin
      $display("toggled load done after cycle %0d", c);
    end
    // ld_start during DONE must be ignored.
    bus.ld_valid = 1'b0;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.ld_done !== 1'b0) begin
      n_err++;
      $display("FAIL done_ignores_start: busy=%b done=%b, required 0 0", bus.busy, bus.ld_done);
    end
    for (int a = 0; a < 16; a++) begin
      do_fetch(ADDR_W'(a), 8'h10 + 8'(a));
    end
  endtask

  task automatic test_fetch_during_load_and_restart();
    int dones = 0;
    do_fetch(4'd7, 8'h17);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 4'd2;
    bus.ld_start   = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    n_cmp++;
    if (bus.fetch_valid !== 1'b1 || bus.instr !== 8'h12 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_with_start: fv=%b instr=%02h busy=%b, required 1 12 1",
               bus.fetch_valid, bus.instr, bus.busy);
    end
    bus.fetch_addr = 4'd9;
    for (int i = 0; i < 6; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'h50 + 8'(i);
      tick();
      n_cmp++;
      if (bus.fetch_valid !== 1'b0 || bus.instr !== 8'h12) begin
        n_err++;
        $display("FAIL fetch_in_load: fv=%b instr=%02h, required fv=0 instr=12",
                 bus.fetch_valid, bus.instr);
      end
    end
    bus.fetch_req = 1'b0;
    bus.ld_start  = 1'b1;
    bus.ld_data   = 8'hEE;
    tick();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'hA0 + 8'(i);
      tick();
      if (bus.ld_done === 1'b1) dones++;
    end
    bus.ld_valid = 1'b0;
    tick();
    if (bus.ld_done === 1'b1) dones++;
    n_cmp++;
    if (dones != 1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL restart_done_count: pulses=%0d busy=%b, required 1 0", dones, bus.busy);
    end
    for (int a = 0; a < 16; a++) begin
      do_fetch(ADDR_W'(a), 8'hA0 + 8'(a));
    end
  endtask

  task automatic test_reset_midload();
    int dones = 0;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'hC0 + 8'(i);
      tick();
    end
    bus.ld_data = 8'hFF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ld_valid = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.ld_done !== 1'b0 || bus.ld_ready !== 1'b0 ||
        bus.fetch_valid !== 1'b0 || bus.instr !== 8'h00) begin
      n_err++;
      $display("FAIL reset_midload: busy=%b done=%b ready=%b fv=%b instr=%02h, required all zero",
               bus.busy, bus.ld_done, bus.ld_ready, bus.fetch_valid, bus.instr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.ld_done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL reset_no_done: pulses=%0d, required 0", dones);
    end
    do_fetch(4'd3, 8'hC3);
    do_fetch(4'd10, 8'hAA);
    do_fetch(4'd6, 8'hA6);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_zero();
    test_load_full();
    test_load_toggle();
    test_fetch_during_load_and_restart();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
